mem_access_stage: RTL and testbench
===================================

// Module: mem_access_stage
// PURPOSE
//  MEM-stage consumer of the EX/MEM pipeline register outputs. Drives the data-memory req/ack port
//  (byte enables, write-data lane steering, load extraction for lb/lbu/lh/lhu/lw) and stalls the pipe
//  while an access is outstanding. Registers the results into the MEM/WB boundary for the WB stage.
// PARAMETERS
//  TIMEOUT     16   max cycles req may wait for ack before bus error (>=2)
//  CNT_W       5    width of wait counter; must hold TIMEOUT
// PORTS
//  clk          in   1   clock
//  rst          in   1   reset, synchronous, active-high
//  PCPlus8M     in   32  link address of M-stage instr
//  ALUOutM      in   32  effective address / ALU result
//  WriteDataM   in   32  store data (forwarded)
//  WriteRegM    in   5   destination register
//  RegWriteM    in   1   instr writes register file
//  MemWriteM    in   1   store
//  MemToRegM    in   1   load
//  IsJJalM      in   1   j/jal in M (selects link data)
//  IsJrJalrM    in   1   jr/jalr in M (selects link data)
//  IsLbSbM      in   1   byte-sized access
//  IsLhShM      in   1   halfword-sized access
//  IsUnsignedM  in   1   zero-extend load
//  IsSyscallM   in   1   syscall in M
//  mem_req      out  1   access request, held until ack
//  mem_we       out  1   1=write
//  mem_addr     out  32  word-aligned address {ALUOutM[31:2],2'b00}
//  mem_be       out  4   byte enables
//  mem_wdata    out  32  lane-replicated store data
//  mem_ack      in   1   access complete; mem_rdata valid this cycle for reads
//  mem_rdata    in   32  read word
//  StallM       out  1   freeze PC/F/D/E/M registers this cycle
//  ResultW      out  32  load data, link data or ALUOutM (registered)
//  WriteRegW    out  5   registered WriteRegM
//  RegWriteW    out  1   registered, gated by errors
//  IsSyscallW   out  1   registered IsSyscallM
//  BusErrW      out  1   registered timeout flag
// BEHAVIOUR
//  access = MemWriteM|MemToRegM. FSM: IDLE, WAIT, HOLD.
//  IDLE: access -> mem_req=1 combinationally; ack same cycle completes (0-wait); else -> WAIT, cnt=1.
//  WAIT: mem_req=1, addr/we/be/wdata stable; ack -> IDLE; cnt==TIMEOUT -> HOLD, bus error.
//  HOLD: one cycle, mem_req=0, StallM=0, completes instr as error -> IDLE.
//  StallM = access & ~mem_ack & state!=HOLD (combinational); 1-cycle min access latency.
//  MEM/WB reg updates only when ~StallM; while StallM, RegWriteW<=0, IsSyscallW<=0 (bubble).
//  be: byte 4'b0001<<a[1:0]; half a[1]?1100:0011; word 1111. Loads use same be.
//  wdata: byte {4{d[7:0]}}, half {2{d[15:0]}}, word d.
//  load: select lane by a[1:0]/a[1]; sign-extend unless IsUnsignedM; word passes through.
//  ResultW = MemToRegM ? load : (IsJJalM|IsJrJalrM) ? PCPlus8M : ALUOutM.
//  Bus error: BusErrW=1, RegWriteW=0, store may have partially taken effect (not retried).
//  Reset: state=IDLE, cnt=0; all W outputs 0; mem_req=0 next cycle (rst overrides access).
//  Reset mid-WAIT abandons request; memory must tolerate dropped req.
//  Store+syscall never coincide (decoder guarantees); no request for non-access instrs.
// CONFIGURATION
//  MISALIGN_TRAP_EN defined: half with a[0]=1 or word with a[1:0]!=0 issues no request, no stall;
//   MisalignW (extra 1-bit out) =1, RegWriteW=0. Undefined: port absent; low addr bits ignored
//   (half uses a[1], word uses a[31:2]), access proceeds.
// STRUCTURE
//  Shared pkg/header: FSM state encodings, BE_BYTE/BE_HALF/BE_WORD constants, size decode.
//  Sub-module mem_lane_align: combinational be/wdata steering and load extraction; FSM+WB reg here.
// TESTING
//  lb a=0x..03, rdata 0x80FF_FF00, signed -> ResultW=0xFFFF_FF80; lbu -> 0x0000_0080.
//  sh a=0x..02, d=0x1234ABCD -> be=1100, wdata=0xABCD_ABCD, mem_we=1, RegWriteW=0.
//  lw, ack after 3 cycles -> StallM high 3 cycles, req/addr stable, ResultW=rdata after ack.
//  no ack for TIMEOUT=16 cycles -> HOLD, BusErrW=1, RegWriteW=0, StallM drops.
//  rst asserted in WAIT -> mem_req=0 and all W outputs 0 next cycle, state IDLE.
//  jal in M, PCPlus8M=0x40 -> ResultW=0x40, no mem_req; lw a=0x..01 w/ MISALIGN_TRAP_EN -> MisalignW=1.

Source files
------------

// File: rtl/mem_access_stage_pkg.sv
// Shared types for the MEM stage: FSM states, byte-enable patterns
// and access-size decode.
package mem_access_stage_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_t;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  function automatic size_t size_dec(
    input logic lb,
    input logic lh
  );
    size_t s;
    unique case (1'b1)
      lb:      s = SZ_BYTE;
      lh:      s = SZ_HALF;
      default: s = SZ_WORD;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for stores and lane extraction for loads.
// Purely combinational; the address low bits select the lane.
module mem_lane_align
  import mem_access_stage_pkg::*;
(
  input  size_t       size,
  input  logic [1:0]  a,
  input  logic        is_unsigned,
  input  logic [31:0] st_data,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load
);

  logic [7:0]  b;
  logic [15:0] h;
  logic        sx_b;
  logic        sx_h;

  always_comb begin
    b = rdata[7:0];
    unique case (a)
      2'd0: b = rdata[7:0];
      2'd1: b = rdata[15:8];
      2'd2: b = rdata[23:16];
      2'd3: b = rdata[31:24];
    endcase
    h = a[1] ? rdata[31:16] : rdata[15:0];
  end

  assign sx_b = b[7] & ~is_unsigned;
  assign sx_h = h[15] & ~is_unsigned;

  always_comb begin
    be    = BE_WORD;
    wdata = st_data;
    load  = rdata;
    unique case (size)
      SZ_BYTE: begin
        be    = BE_BYTE << a;
        wdata = {4{st_data[7:0]}};
        load  = {{24{sx_b}}, b};
      end
      SZ_HALF: begin
        be    = a[1] ? (BE_HALF << 2) : BE_HALF;
        wdata = {2{st_data[15:0]}};
        load  = {{16{sx_h}}, h};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: data-memory req/ack sequencing, stall and MEM/WB register.
// MISALIGN_TRAP_EN adds MisalignW and suppresses misaligned accesses.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] PCPlus8M,
  input  logic [31:0] ALUOutM,
  input  logic [31:0] WriteDataM,
  input  logic [4:0]  WriteRegM,
  input  logic        RegWriteM,
  input  logic        MemWriteM,
  input  logic        MemToRegM,
  input  logic        IsJJalM,
  input  logic        IsJrJalrM,
  input  logic        IsLbSbM,
  input  logic        IsLhShM,
  input  logic        IsUnsignedM,
  input  logic        IsSyscallM,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        StallM,
  output logic [31:0] ResultW,
  output logic [4:0]  WriteRegW,
  output logic        RegWriteW,
  output logic        IsSyscallW,
  output logic        BusErrW
`ifdef MISALIGN_TRAP_EN
  ,
  output logic        MisalignW
`endif
);

  state_t      state;
  state_t      state_n;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_n;
  size_t       size;
  logic        access;
  logic        misalign;
  logic        go;
  logic        bus_err;
  logic        req;
  logic [31:0] load;
  logic [31:0] result;

  assign access = MemWriteM | MemToRegM;
  assign size   = size_dec(IsLbSbM, IsLhShM);

`ifdef MISALIGN_TRAP_EN
  assign misalign = access &
    (((size == SZ_HALF) & ALUOutM[0]) |
     ((size == SZ_WORD) & (|ALUOutM[1:0])));
`else
  assign misalign = 1'b0;
`endif

  assign go = access & ~misalign;

  mem_lane_align u_align (
    .size        (size),
    .a           (ALUOutM[1:0]),
    .is_unsigned (IsUnsignedM),
    .st_data     (WriteDataM),
    .rdata       (mem_rdata),
    .be          (mem_be),
    .wdata       (mem_wdata),
    .load        (load)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    unique case (state)
      S_IDLE: begin
        if (go & ~mem_ack) begin
          state_n = S_WAIT;
          cnt_n   = CNT_W'(1);
        end
      end
      S_WAIT: begin
        if (mem_ack) begin
          state_n = S_IDLE;
          cnt_n   = '0;
        end else if (cnt == CNT_W'(TIMEOUT)) begin
          state_n = S_HOLD;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      S_HOLD: begin
        state_n = S_IDLE;
        cnt_n   = '0;
      end
      default: begin
        state_n = S_IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  always_comb begin
    req     = 1'b0;
    bus_err = 1'b0;
    unique case (state)
      S_IDLE:  req = go;
      S_WAIT:  req = 1'b1;
      S_HOLD:  bus_err = 1'b1;
      default: ;
    endcase
  end

  // Reset drops any pending request immediately.
  assign mem_req  = req & ~rst;
  assign mem_we   = MemWriteM & go;
  assign mem_addr = {ALUOutM[31:2], 2'b00};
  assign StallM   = go & ~mem_ack & (state != S_HOLD);

  assign result = MemToRegM ? load :
                  (IsJJalM | IsJrJalrM) ? PCPlus8M :
                  ALUOutM;

  always_ff @(posedge clk) begin
    if (rst) begin
      ResultW    <= '0;
      WriteRegW  <= '0;
      RegWriteW  <= 1'b0;
      IsSyscallW <= 1'b0;
      BusErrW    <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      MisalignW  <= 1'b0;
`endif
    end else if (StallM) begin
      RegWriteW  <= 1'b0;
      IsSyscallW <= 1'b0;
      BusErrW    <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      MisalignW  <= 1'b0;
`endif
    end else begin
      ResultW    <= result;
      WriteRegW  <= WriteRegM;
      RegWriteW  <= RegWriteM & ~bus_err & ~misalign;
      IsSyscallW <= IsSyscallM;
      BusErrW    <= bus_err;
`ifdef MISALIGN_TRAP_EN
      MisalignW  <= misalign;
`endif
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Randomised scoreboard bench for mem_access_stage with a
// behavioural memory responder and reference model.
module tb_mem_access_stage;

  localparam int TIMEOUT = 16;
  localparam int K_ALU = 0, K_JAL = 1, K_JR = 2;
  localparam int K_LD = 3, K_ST = 4, K_SYS = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] PCPlus8M, ALUOutM, WriteDataM;
  logic [4:0]  WriteRegM;
  logic        RegWriteM, MemWriteM, MemToRegM;
  logic        IsJJalM, IsJrJalrM, IsLbSbM, IsLhShM;
  logic        IsUnsignedM, IsSyscallM;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        StallM;
  logic [31:0] ResultW;
  logic [4:0]  WriteRegW;
  logic        RegWriteW, IsSyscallW, BusErrW;
`ifdef MISALIGN_TRAP_EN
  logic        MisalignW;
`endif

  always #5 clk = ~clk;

  mem_access_stage #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
    .clk(clk), .rst(rst),
    .PCPlus8M(PCPlus8M), .ALUOutM(ALUOutM),
    .WriteDataM(WriteDataM), .WriteRegM(WriteRegM),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM),
    .MemToRegM(MemToRegM), .IsJJalM(IsJJalM),
    .IsJrJalrM(IsJrJalrM), .IsLbSbM(IsLbSbM),
    .IsLhShM(IsLhShM), .IsUnsignedM(IsUnsignedM),
    .IsSyscallM(IsSyscallM),
    .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .StallM(StallM),
    .ResultW(ResultW), .WriteRegW(WriteRegW),
    .RegWriteW(RegWriteW), .IsSyscallW(IsSyscallW),
    .BusErrW(BusErrW)
`ifdef MISALIGN_TRAP_EN
    , .MisalignW(MisalignW)
`endif
  );

  typedef struct {
    int          kind;
    int          size;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] rdata;
    logic [31:0] pc8;
    logic [4:0]  rd;
    logic        uns;
    int          delay;
  } ins_t;

  typedef struct {
    logic [31:0] result;
    logic [4:0]  wreg;
    logic        regwrite;
    logic        syscall;
    logic        buserr;
    logic        misalign;
    logic        chk_result;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passed = 0;
  logic active = 1'b0;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic ins_t mk(int kind, int size,
      logic [31:0] addr, logic [31:0] data,
      logic [31:0] rdata, logic uns, int delay,
      logic [4:0] rd, logic [31:0] pc8);
    ins_t i;
    i.kind = kind; i.size = size; i.addr = addr;
    i.data = data; i.rdata = rdata; i.uns = uns;
    i.delay = delay; i.rd = rd; i.pc8 = pc8;
    return i;
  endfunction

  function automatic bit is_mem(ins_t i);
    return i.kind == K_LD || i.kind == K_ST;
  endfunction

  function automatic bit misaligned(ins_t i);
`ifdef MISALIGN_TRAP_EN
    if (!is_mem(i)) return 0;
    if (i.size == 2) return i.addr[0];
    if (i.size == 4) return i.addr[1:0] != 2'd0;
    return 0;
`else
    return 0;
`endif
  endfunction

  // Reference load: pick the addressed bytes arithmetically.
  function automatic logic [31:0] ref_load(ins_t i);
    int off;
    logic [31:0] v;
    if (i.size == 4) return i.rdata;
    off = (i.size == 2) ? 2 * int'(i.addr[1]) : int'(i.addr[1:0]);
    v = i.rdata >> (8 * off);
    if (i.size == 1) begin
      v = v & 32'hFF;
      if (!i.uns && v[7]) v = v | 32'hFFFF_FF00;
    end else begin
      v = v & 32'hFFFF;
      if (!i.uns && v[15]) v = v | 32'hFFFF_0000;
    end
    return v;
  endfunction

  function automatic logic [3:0] ref_be(ins_t i);
    logic [3:0] one = 4'h1;
    logic [3:0] two = 4'h3;
    if (i.size == 1) return one << i.addr[1:0];
    if (i.size == 2) return two << (2 * int'(i.addr[1]));
    return 4'hF;
  endfunction

  function automatic logic [31:0] ref_wdata(ins_t i);
    if (i.size == 1) return {24'd0, i.data[7:0]} * 32'h0101_0101;
    if (i.size == 2) return {16'd0, i.data[15:0]} * 32'h0001_0001;
    return i.data;
  endfunction

  task automatic apply(ins_t i);
    bit m = is_mem(i);
    PCPlus8M    = i.pc8;
    ALUOutM     = i.addr;
    WriteDataM  = i.data;
    WriteRegM   = i.rd;
    RegWriteM   = i.kind <= K_LD;
    MemWriteM   = i.kind == K_ST;
    MemToRegM   = i.kind == K_LD;
    IsJJalM     = i.kind == K_JAL;
    IsJrJalrM   = i.kind == K_JR;
    IsLbSbM     = m && i.size == 1;
    IsLhShM     = m && i.size == 2;
    IsUnsignedM = i.uns;
    IsSyscallM  = i.kind == K_SYS;
    mem_rdata   = i.rdata;
  endtask

  // Drive one instruction, act as memory, push the expected WB entry.
  task automatic issue(ins_t i);
    exp_t e;
    bit acc, mis, tmo, req_exp, s, done;
    int stalls, exp_stalls;
    acc = is_mem(i);
    mis = misaligned(i);
    tmo = acc && !mis && i.delay > TIMEOUT;
    @(negedge clk);
    apply(i);
    mem_ack = 1'b0;
    active = 1'b1;
    if (i.kind == K_LD) e.result = ref_load(i);
    else if (i.kind == K_JAL || i.kind == K_JR) e.result = i.pc8;
    else e.result = i.addr;
    e.wreg = i.rd;
    e.regwrite = (i.kind <= K_LD) && !tmo && !mis;
    e.syscall = i.kind == K_SYS;
    e.buserr = tmo;
    e.misalign = mis;
    e.chk_result = !tmo;
    sb.push_back(e);
    stalls = 0;
    done = 0;
    for (int k = 0; k < 64; k++) begin
      mem_ack = acc && !mis && (k == i.delay);
      #1;
      req_exp = acc && !mis && (tmo ? k <= TIMEOUT : k <= i.delay);
      check("mem_req", {31'd0, mem_req}, {31'd0, req_exp});
      if (req_exp && mem_req) begin
        check("mem_addr", mem_addr, {i.addr[31:2], 2'b00});
        check("mem_we", {31'd0, mem_we}, (i.kind == K_ST) ? 1 : 0);
        check("mem_be", {28'd0, mem_be}, {28'd0, ref_be(i)});
        if (i.kind == K_ST)
          check("mem_wdata", mem_wdata, ref_wdata(i));
      end
      s = StallM;
      if (s) stalls++;
      @(posedge clk);
      if (!s) begin
        done = 1;
        break;
      end
      @(negedge clk);
    end
    if (!done) $display("FAIL retire_timeout: instr never retired");
    exp_stalls = (!acc || mis) ? 0 : tmo ? TIMEOUT + 1 : i.delay;
    check("stall_cycles", stalls, exp_stalls);
    #1;
    active = 1'b0;
    mem_ack = 1'b0;
  endtask

  // Monitor: each retiring cycle pops one expectation.
  logic m_act, m_st, m_rst;
  exp_t me;
  always @(posedge clk) begin
    m_act = active;
    m_st  = StallM;
    m_rst = rst;
    #1;
    if (m_act && !m_st && !m_rst) begin
      if (sb.size() == 0) begin
        checks++;
        $display("FAIL scoreboard: retire with empty queue");
      end else begin
        me = sb.pop_front();
        check("RegWriteW", {31'd0, RegWriteW}, {31'd0, me.regwrite});
        check("WriteRegW", {27'd0, WriteRegW}, {27'd0, me.wreg});
        check("IsSyscallW", {31'd0, IsSyscallW}, {31'd0, me.syscall});
        check("BusErrW", {31'd0, BusErrW}, {31'd0, me.buserr});
`ifdef MISALIGN_TRAP_EN
        check("MisalignW", {31'd0, MisalignW}, {31'd0, me.misalign});
`endif
        if (me.chk_result) check("ResultW", ResultW, me.result);
      end
    end
  end

  initial begin
    ins_t r;
    int sz;
    rst = 1'b1;
    mem_ack = 1'b0;
    apply(mk(K_ALU, 4, 0, 0, 0, 0, 0, 0, 0));
    repeat (3) @(posedge clk);
    #1;
    check("rst_req", {31'd0, mem_req}, 0);
    check("rst_ResultW", ResultW, 0);
    check("rst_RegWriteW", {31'd0, RegWriteW}, 0);
    check("rst_BusErrW", {31'd0, BusErrW}, 0);
    @(negedge clk);
    rst = 1'b0;

    issue(mk(K_LD, 1, 32'h0000_1003, 0, 32'h80FF_FF00, 0, 1, 5'd3, 0));
    check("lb_signed", ResultW, 32'hFFFF_FF80);
    issue(mk(K_LD, 1, 32'h0000_1003, 0, 32'h80FF_FF00, 1, 0, 5'd4, 0));
    check("lbu", ResultW, 32'h0000_0080);
    issue(mk(K_ST, 2, 32'h0000_2002, 32'h1234_ABCD, 0, 0, 1, 5'd0, 0));
    check("sh_regwrite", {31'd0, RegWriteW}, 0);
    issue(mk(K_LD, 4, 32'h0000_3000, 0, 32'hDEAD_BEEF, 0, 3, 5'd9, 0));
    check("lw_wait3", ResultW, 32'hDEAD_BEEF);
    issue(mk(K_LD, 4, 32'h0000_3004, 0, 32'h1111_2222, 0, 255, 5'd9, 0));
    check("timeout_buserr", {31'd0, BusErrW}, 1);
    check("timeout_regwrite", {31'd0, RegWriteW}, 0);
    issue(mk(K_JAL, 4, 32'h0000_0123, 0, 0, 0, 0, 5'd31, 32'h40));
    check("jal_link", ResultW, 32'h0000_0040);
`ifdef MISALIGN_TRAP_EN
    issue(mk(K_LD, 4, 32'h0000_4001, 0, 32'h5555_AAAA, 0, 0, 5'd6, 0));
    check("misalign_flag", {31'd0, MisalignW}, 1);
`endif

    // Reset while a request is waiting for ack.
    @(negedge clk);
    apply(mk(K_LD, 4, 32'h0000_0100, 0, 32'h55, 0, 255, 5'd7, 0));
    mem_ack = 1'b0;
    active = 1'b1;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
    end
    #1;
    check("wait_req", {31'd0, mem_req}, 1);
    check("wait_stall", {31'd0, StallM}, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rstw_req", {31'd0, mem_req}, 0);
    check("rstw_ResultW", ResultW, 0);
    check("rstw_WriteRegW", {27'd0, WriteRegW}, 0);
    check("rstw_RegWriteW", {31'd0, RegWriteW}, 0);
    check("rstw_IsSyscallW", {31'd0, IsSyscallW}, 0);
    check("rstw_BusErrW", {31'd0, BusErrW}, 0);
    @(negedge clk);
    active = 1'b0;
    apply(mk(K_ALU, 4, 0, 0, 0, 0, 0, 0, 0));
    rst = 1'b0;
    issue(mk(K_LD, 4, 32'h0000_0200, 0, 32'hCAFE_F00D, 0, 0, 5'd8, 0));
    check("post_rst_lw", ResultW, 32'hCAFE_F00D);

    for (int n = 0; n < 300; n++) begin
      sz = $urandom_range(0, 2);
      r.kind  = $urandom_range(0, 5);
      r.size  = (sz == 0) ? 1 : (sz == 1) ? 2 : 4;
      r.addr  = $urandom;
      r.data  = $urandom;
      r.rdata = $urandom;
      r.pc8   = $urandom;
      r.rd    = 5'($urandom_range(1, 31));
      r.uns   = 1'($urandom_range(0, 1));
      r.delay = ($urandom_range(0, 19) == 0) ? 255
                                             : $urandom_range(0, 5);
      issue(r);
    end

    repeat (2) @(posedge clk);
    if (sb.size() != 0) begin
      checks++;
      $display("FAIL scoreboard_drain: %0d entries left, 0 required",
               sb.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
